// File: rtl/id_ex_stage.sv
// Decode/register-read stage: decodes one instruction, reads the register file
// with writeback bypass, and holds a single entry for execute behind valid/ready.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_ctrl,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm
);

    logic [31:0] regs [32];

    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        legal;
    logic        use_imm;
    logic [2:0]  d_ctrl;
    logic        d_we;
    logic [4:0]  d_rd;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [31:0] d_imm;

    assign op  = in_instr[31:28];
    assign rd  = in_instr[27:23];
    assign rs1 = in_instr[22:18];
    assign rs2 = in_instr[17:13];
    assign imm = {{19{in_instr[12]}}, in_instr[12:0]};

    // A same-cycle writeback to the register being read wins over the array.
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (rs1 == 5'd0)
            rs1_val = 32'd0;
        else if (wb_we && wb_rd == rs1)
            rs1_val = wb_data;
        if (rs2 == 5'd0)
            rs2_val = 32'd0;
        else if (wb_we && wb_rd == rs2)
            rs2_val = wb_data;
    end

    always_comb begin
        legal   = 1'b1;
        use_imm = 1'b0;
        d_ctrl  = 3'b000;
        d_we    = 1'b0;
        case (op)
            4'd1: begin d_ctrl = 3'b000; d_we = 1'b1; end
            4'd2: begin d_ctrl = 3'b001; d_we = 1'b1; end
            4'd3: begin d_ctrl = 3'b011; d_we = 1'b1; end
            4'd4: begin d_ctrl = 3'b100; d_we = 1'b1; end
            4'd5: begin d_ctrl = 3'b000; d_we = 1'b1; use_imm = 1'b1; end
            4'd6: begin d_ctrl = 3'b010; d_we = 1'b0; end
            default: legal = 1'b0;
        endcase
        d_rd  = legal ? rd : 5'd0;
        d_a   = legal ? rs1_val : 32'd0;
        d_b   = legal ? (use_imm ? imm : rs2_val) : 32'd0;
        d_imm = legal ? imm : 32'd0;
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Flush beats both a new accept and a stalled hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= 32'd0;
            out_b     <= 32'd0;
            out_ctrl  <= 3'b000;
            out_rd    <= 5'd0;
            out_we    <= 1'b0;
            out_pc    <= 32'd0;
            out_imm   <= 32'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_a     <= d_a;
            out_b     <= d_b;
            out_ctrl  <= d_ctrl;
            out_rd    <= d_rd;
            out_we    <= d_we;
            out_pc    <= in_pc;
            out_imm   <= d_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, bypass, stall, flush and reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [31:0] out_pc;
    logic [31:0] out_imm;

    int tests = 0;
    int fails = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_we(out_we),
        .out_pc(out_pc), .out_imm(out_imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a", out_a, 32'd0);
        check("rst_ctrl", {29'd0, out_ctrl}, 32'd0);
        check("rst_imm", out_imm, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        step();
        wb_rd = 5'd2; wb_data = 32'd3;
        step();
        wb_we = 1'b0;

        in_valid = 1'b1; in_pc = 32'h100;
        in_instr = enc(4'd1, 5'd3, 5'd1, 5'd2, 13'd0);
        step();
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_a", out_a, 32'd5);
        check("add_b", out_b, 32'd3);
        check("add_ctrl", {29'd0, out_ctrl}, 32'd0);
        check("add_we", {31'd0, out_we}, 32'd1);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_pc", out_pc, 32'h100);

        in_pc = 32'h104;
        in_instr = enc(4'd5, 5'd5, 5'd1, 5'd0, 13'h1FFF);
        step();
        check("addi_a", out_a, 32'd5);
        check("addi_b", out_b, 32'hFFFFFFFF);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_ctrl", {29'd0, out_ctrl}, 32'd0);

        in_pc = 32'h108;
        in_instr = enc(4'd2, 5'd6, 5'd1, 5'd2, 13'd0);
        step();
        check("sub_ctrl", {29'd0, out_ctrl}, 32'd1);
        out_ready = 1'b0;
        in_pc = 32'h10C;
        in_instr = enc(4'd4, 5'd7, 5'd1, 5'd2, 13'd0);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall1_ctrl", {29'd0, out_ctrl}, 32'd1);
        check("stall1_rd", {27'd0, out_rd}, 32'd6);
        check("stall1_pc", out_pc, 32'h108);
        step();
        check("stall2_valid", {31'd0, out_valid}, 32'd1);
        check("stall2_rd", {27'd0, out_rd}, 32'd6);
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("or_ctrl", {29'd0, out_ctrl}, 32'd4);
        check("or_rd", {27'd0, out_rd}, 32'd7);
        check("or_pc", out_pc, 32'h10C);

        in_instr = enc(4'd3, 5'd8, 5'd4, 5'd2, 13'd0);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hA5A5A5A5;
        step();
        check("bypass_a", out_a, 32'hA5A5A5A5);
        check("and_ctrl", {29'd0, out_ctrl}, 32'd3);
        wb_rd = 5'd0; wb_data = 32'hDEADBEEF; in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        wb_we = 1'b0;
        in_valid = 1'b1;
        in_instr = enc(4'd1, 5'd9, 5'd0, 5'd4, 13'd0);
        step();
        check("r0_read", out_a, 32'd0);
        check("r4_read", out_b, 32'hA5A5A5A5);

        out_ready = 1'b0; flush = 1'b1;
        in_instr = enc(4'd6, 5'd1, 5'd1, 5'd2, 13'd0);
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_no_blt", {31'd0, out_valid}, 32'd0);
        check("flush_no_blt_ctrl", {29'd0, out_ctrl}, 32'd0);

        in_valid = 1'b1;
        step();
        check("blt_ctrl", {29'd0, out_ctrl}, 32'd2);
        check("blt_we", {31'd0, out_we}, 32'd0);
        out_ready = 1'b1;
        in_instr = enc(4'd9, 5'd3, 5'd1, 5'd2, 13'd7);
        step();
        check("nop_valid", {31'd0, out_valid}, 32'd1);
        check("nop_we", {31'd0, out_we}, 32'd0);
        check("nop_ctrl", {29'd0, out_ctrl}, 32'd0);
        check("nop_rd", {27'd0, out_rd}, 32'd0);
        check("nop_a", out_a, 32'd0);

        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("held_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; out_ready = 1'b1;
        in_instr = enc(4'd1, 5'd3, 5'd1, 5'd2, 13'd0);
        step();
        check("rf_cleared_a", out_a, 32'd0);
        check("rf_cleared_b", out_b, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-002 SHALL have: in_valid in 1, fetch presents instruction; in_ready out 1, stage accepts instruction this cycle.
REQ-003 SHALL have: in_instr in 32, instruction word; in_pc in 32, PC of in_instr.
REQ-004 SHALL have: wb_we in 1, writeback enable; wb_rd in 5, writeback register; wb_data in 32, writeback value.
REQ-005 SHALL have: flush in 1, branch taken in execute, discard younger work.
REQ-006 SHALL have: out_valid out 1; out_ready in 1, execute accepts held entry.
REQ-007 SHALL have: out_a out 32, ALU operand A; out_b out 32, ALU operand B; out_ctrl out 3, ALU control code.
REQ-008 SHALL have: out_rd out 5, destination register; out_we out 1, destination write enable; out_pc out 32; out_imm out 32, sign-extended immediate.

Function
REQ-009 SHALL decode in_instr fields: [31:28] opcode, [27:23] rd, [22:18] rs1, [17:13] rs2, [12:0] imm; imm SHALL be sign-extended from bit 12 to 32 bits.
REQ-010 SHALL map opcodes to out_ctrl/out_we/B-source: 1 ADD 000/1/rs2; 2 SUB 001/1/rs2; 3 AND 011/1/rs2; 4 OR 100/1/rs2; 5 ADDI 000/1/imm; 6 BLT 010/0/rs2.
REQ-011 SHALL treat opcode 0 and opcodes 7-15 as NOP: out_ctrl 000, out_we 0, out_rd 0, operands 0.
REQ-012 SHALL contain a 32x32 register file; register 0 SHALL read 0 and ignore writes.
REQ-013 SHALL write wb_data to wb_rd on the clk edge when wb_we=1 and wb_rd!=0.
REQ-014 SHALL bypass: a read of rs1/rs2 equal to a nonzero wb_rd with wb_we=1 in the same cycle SHALL return wb_data.
REQ-015 SHALL hold one output entry; in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL, on a clk edge with in_valid && in_ready && !flush, load the decoded entry and set out_valid=1; latency in_valid-accept to out_valid SHALL be 1 cycle.
REQ-017 SHALL, on a clk edge with out_valid && out_ready and no new accept, clear out_valid.
REQ-018 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-019 SHALL, on a clk edge with flush=1, clear out_valid and discard any concurrently offered in_instr; flush SHALL override accept and stall.
REQ-020 SHALL keep register-file writes active during stall and flush.
REQ-021 SHALL perform no ALU arithmetic; operands are forwarded unmodified.

Reset
REQ-022 SHALL, while reset=1, asynchronously force out_valid=0, out_a=0, out_b=0, out_ctrl=000, out_rd=0, out_we=0, out_pc=0, out_imm=0.
REQ-023 SHALL clear all 32 registers to 0 on reset.
REQ-024 SHALL drop any held entry when reset asserts mid-operation; in_ready SHALL read 1 after reset deasserts.

Verification
REQ-025 SHALL check: reset, write r1=5, r2=3, ADD rd=3 rs1=1 rs2=2, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=3, out_ctrl=000, out_we=1, out_rd=3.
REQ-026 SHALL check: ADDI rs1=1 imm=0x1FFF -> out_b=0xFFFFFFFF, out_imm=0xFFFFFFFF, out_ctrl=000.
REQ-027 SHALL check: out_ready=0 two cycles with SUB held then OR offered -> in_ready=0, outputs unchanged, OR appears cycle after out_ready=1.
REQ-028 SHALL check: wb_we=1 wb_rd=4 wb_data=0xA5A5A5A5 same cycle as AND rs1=4 -> out_a=0xA5A5A5A5; write to r0 -> later read r0=0.
REQ-029 SHALL check: flush=1 with in_valid=1 BLT and held entry -> next cycle out_valid=0, BLT not issued.
REQ-030 SHALL check: opcode 9 -> NOP entry out_we=0 out_ctrl=000; reset asserted while out_valid=1 -> out_valid=0 immediately.
